// File: rtl/sm2201_latch_sequencer.sv
// sm2201_latch_sequencer
// Drives a bank of octal edge-triggered output latches on the CAMAC side of
// the SM2201 ISA-CAMAC board. Two requesters (ISA host, CAMAC cycle engine)
// are arbitrated round-robin. Each write runs SETUP -> STROBE -> HOLD -> ACK
// on a shared data bus with a per-latch strobe. Each latch's OE is gated by
// its valid bit and the global out_en.
//
// Optional build macro SM2201_LATCH_SHADOW_EN: keeps a per-latch copy of the
// last strobed value, read back through shadow_addr/shadow_data. Without it,
// shadow_data is tied to zero and shadow_addr is ignored.
module sm2201_latch_sequencer #(
   parameter int NUM_LATCHES   = 4,
   parameter int ADDR_WIDTH    = 2,
   parameter int DATA_WIDTH    = 8,
   parameter int SETUP_CYCLES  = 2,
   parameter int STROBE_CYCLES = 1,
   parameter int HOLD_CYCLES   = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   isa_req,
   input  logic [ADDR_WIDTH-1:0]  isa_addr,
   input  logic [DATA_WIDTH-1:0]  isa_data,
   output logic                   isa_ack,
   input  logic                   camac_req,
   input  logic [ADDR_WIDTH-1:0]  camac_addr,
   input  logic [DATA_WIDTH-1:0]  camac_data,
   output logic                   camac_ack,
   input  logic                   out_en,
   output logic [DATA_WIDTH-1:0]  latch_data,
   output logic [NUM_LATCHES-1:0] latch_clk,
   output logic [NUM_LATCHES-1:0] latch_oe_n,
   output logic                   busy,
   output logic                   addr_err,
   input  logic                   err_clr,
   input  logic [ADDR_WIDTH-1:0]  shadow_addr,
   output logic [DATA_WIDTH-1:0]  shadow_data
);

   localparam int MAX_SH  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
   localparam int MAX_CYC = (MAX_SH > HOLD_CYCLES) ? MAX_SH : HOLD_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_ACK
   } state_t;

   // Captured write: which requester, target latch and data
   typedef struct packed {
      logic                  from_camac;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } req_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q;
   req_t                   req_q, grant_req;
   logic                   grant, grant_cam;
   logic                   rr_cam_q;      // 1: CAMAC wins the next tie
   logic [NUM_LATCHES-1:0] sel_oh;        // all zero for an out-of-range index
   logic [NUM_LATCHES-1:0] latch_clk_q;
   logic [NUM_LATCHES-1:0] valid_q;
   logic [NUM_LATCHES-1:0] oe_n_q;
   logic                   addr_err_q;
   logic                   strobe_entry, hold_entry;

   // Decode the captured index; out-of-range indices select no latch
   always_comb begin
      sel_oh = '0;
      for (int i = 0; i < NUM_LATCHES; i++)
         sel_oh[i] = (int'(req_q.addr) == i);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state, round-robin grant and the request selected by the grant
   always_comb begin
      state_d   = state_q;
      grant     = 1'b0;
      grant_cam = 1'b0;
      grant_req = '{1'b0, isa_addr, isa_data};
      unique case (state_q)
         S_IDLE: begin
            if (isa_req || camac_req) begin
               grant     = 1'b1;
               grant_cam = camac_req && (!isa_req || rr_cam_q);
               state_d   = S_SETUP;
            end
         end
         S_SETUP:  if (cnt_q == CNT_W'(SETUP_CYCLES - 1))  state_d = S_STROBE;
         S_STROBE: if (cnt_q == CNT_W'(STROBE_CYCLES - 1)) state_d = S_HOLD;
         S_HOLD:   if (cnt_q == CNT_W'(HOLD_CYCLES - 1))   state_d = S_ACK;
         S_ACK:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (grant_cam) grant_req = '{1'b1, camac_addr, camac_data};
   end

   assign strobe_entry = (state_q == S_SETUP)  && (state_d == S_STROBE);
   assign hold_entry   = (state_q == S_STROBE) && (state_d == S_HOLD);

   // Per-state dwell counter, restarted on every state change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (state_d != state_q || state_q == S_IDLE)
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + 1'b1;
   end

   // Request capture, priority pointer, strobes, valid bits and error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q       <= '0;
         rr_cam_q    <= 1'b0;
         latch_clk_q <= '0;
         valid_q     <= '0;
         addr_err_q  <= 1'b0;
      end else begin
         if (grant) begin
            req_q    <= grant_req;
            rr_cam_q <= !grant_cam;
         end
         latch_clk_q <= (state_d == S_STROBE) ? sel_oh : '0;
         if (hold_entry)
            valid_q <= valid_q | sel_oh;
         // A new error outranks a simultaneous clear
         if (strobe_entry && !(|sel_oh))
            addr_err_q <= 1'b1;
         else if (err_clr)
            addr_err_q <= 1'b0;
      end
   end

   // Registered output enables so the OE pins never glitch on out_en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) oe_n_q <= '1;
      else        oe_n_q <= ~(valid_q & {NUM_LATCHES{out_en}});
   end

   assign latch_data = req_q.data;
   assign latch_clk  = latch_clk_q;
   assign latch_oe_n = oe_n_q;
   assign addr_err   = addr_err_q;
   assign busy       = (state_q != S_IDLE);
   assign isa_ack    = (state_q == S_ACK) && !req_q.from_camac;
   assign camac_ack  = (state_q == S_ACK) &&  req_q.from_camac;

`ifdef SM2201_LATCH_SHADOW_EN
   logic [NUM_LATCHES-1:0][DATA_WIDTH-1:0] shadow_q;

   // Copy the strobed value into the target latch's shadow on HOLD entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
      end else if (hold_entry) begin
         for (int i = 0; i < NUM_LATCHES; i++)
            if (sel_oh[i]) shadow_q[i] <= req_q.data;
      end
   end

   // Combinational read-back; out-of-range indices read zero
   always_comb begin
      shadow_data = '0;
      for (int i = 0; i < NUM_LATCHES; i++)
         if (int'(shadow_addr) == i) shadow_data = shadow_q[i];
   end
`else
   logic unused_shadow_addr;
   assign unused_shadow_addr = ^shadow_addr;
   assign shadow_data        = '0;
`endif

endmodule

// File: tb/tb_sm2201_latch_sequencer.sv
// Self-checking bench for sm2201_latch_sequencer. Two instances: the default
// four-latch build, and a three-latch build so index 3 is out of range.
module tb_sm2201_latch_sequencer;

   localparam int N  = 4;
   localparam int N3 = 3;
   localparam int AW = 2;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic isa_req, camac_req, out_en, err_clr;
   logic [AW-1:0] isa_addr, camac_addr, shadow_addr;
   logic [DW-1:0] isa_data, camac_data;
   logic isa_ack, camac_ack, busy, addr_err;
   logic [DW-1:0] latch_data, shadow_data;
   logic [N-1:0]  latch_clk, latch_oe_n;

   logic r3_req, c3_req;
   logic [AW-1:0] r3_addr, c3_addr;
   logic [DW-1:0] r3_data, c3_data;
   logic r3_ack, c3_ack, r3_busy, r3_addr_err;
   logic [DW-1:0] r3_latch_data, r3_shadow;
   logic [N3-1:0] r3_latch_clk, r3_oe_n;

   int vec  = 0;
   int errs = 0;

   // Reference model state
   bit            m_ptr_cam;
   bit [N-1:0]    m_valid;
   logic [DW-1:0] m_shadow [N];
   bit [N3-1:0]   m3_valid;
   bit            m3_err;

   always #5 clk = ~clk;

   sm2201_latch_sequencer #(.NUM_LATCHES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .isa_req(isa_req), .isa_addr(isa_addr), .isa_data(isa_data), .isa_ack(isa_ack),
      .camac_req(camac_req), .camac_addr(camac_addr), .camac_data(camac_data), .camac_ack(camac_ack),
      .out_en(out_en), .latch_data(latch_data), .latch_clk(latch_clk), .latch_oe_n(latch_oe_n),
      .busy(busy), .addr_err(addr_err), .err_clr(err_clr),
      .shadow_addr(shadow_addr), .shadow_data(shadow_data)
   );

   sm2201_latch_sequencer #(.NUM_LATCHES(N3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .isa_req(r3_req), .isa_addr(r3_addr), .isa_data(r3_data), .isa_ack(r3_ack),
      .camac_req(c3_req), .camac_addr(c3_addr), .camac_data(c3_data), .camac_ack(c3_ack),
      .out_en(out_en), .latch_data(r3_latch_data), .latch_clk(r3_latch_clk), .latch_oe_n(r3_oe_n),
      .busy(r3_busy), .addr_err(r3_addr_err), .err_clr(err_clr),
      .shadow_addr(shadow_addr), .shadow_data(r3_shadow)
   );

   function automatic logic [DW-1:0] shadow_exp(input logic [AW-1:0] a);
`ifdef SM2201_LATCH_SHADOW_EN
      return m_shadow[a];
`else
      return '0;
`endif
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      isa_req = 1'b0; camac_req = 1'b0; r3_req = 1'b0; err_clr = 1'b0;
      m_ptr_cam = 1'b0; m_valid = '0; m3_valid = '0; m3_err = 1'b0;
      foreach (m_shadow[i]) m_shadow[i] = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Issue requests on the main instance and follow every resulting write
   // cycle by cycle; the model picks the winner from the round-robin rule.
   task automatic run_pair(input bit use_i, input bit use_c,
                           input logic [AW-1:0] ia, input logic [DW-1:0] id,
                           input logic [AW-1:0] ca, input logic [DW-1:0] cd);
      bit pi, pc, wc;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [N-1:0]  oh, eclk, eoe;
      logic [14:0]   got, exp;
      @(posedge clk); #1;
      isa_req = use_i; isa_addr = ia; isa_data = id;
      camac_req = use_c; camac_addr = ca; camac_data = cd;
      pi = use_i; pc = use_c;
      while (pi || pc) begin
         wc = pc && (!pi || m_ptr_cam);
         m_ptr_cam = !wc;
         a = wc ? ca : ia;
         d = wc ? cd : id;
         oh = 1; oh = oh << a;
         @(posedge clk);
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 3) begin m_valid = m_valid | oh; m_shadow[a] = d; end
            eclk = (k == 2) ? oh : {N{1'b0}};
            exp = {(k < 5), eclk, (k == 4 && !wc), (k == 4 && wc), d};
            got = {busy, latch_clk, isa_ack, camac_ack, latch_data};
            vec++;
            if (got !== exp) begin
               errs++;
               $display("FAIL write_seq k=%0d cam=%0b addr=%0d got=%h exp=%h", k, wc, a, got, exp);
            end
            if (k == 4) shadow_addr = AW'($urandom);
            if (k == 5) begin
               eoe = ~(m_valid & {N{out_en}});
               vec++;
               if (latch_oe_n !== eoe) begin
                  errs++;
                  $display("FAIL oe_after_write got=%b exp=%b", latch_oe_n, eoe);
               end
               vec++;
               if (shadow_data !== shadow_exp(shadow_addr)) begin
                  errs++;
                  $display("FAIL shadow_read addr=%0d got=%h exp=%h", shadow_addr, shadow_data, shadow_exp(shadow_addr));
               end
               if (wc) begin camac_req = 1'b0; pc = 1'b0; end
               else    begin isa_req   = 1'b0; pi = 1'b0; end
            end
            if (k < 5) @(posedge clk);
         end
      end
   endtask

   // One ISA write on the three-latch instance, err_clr held at clr
   task automatic r3_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit clr);
      bit bad;
      logic [N3-1:0] oh, eoe;
      logic [13:0]   got, exp;
      bad = (a >= AW'(N3));
      oh = 1; oh = oh << a;
      if (bad) oh = '0;
      @(posedge clk); #1;
      r3_req = 1'b1; r3_addr = a; r3_data = d; err_clr = clr;
      @(posedge clk);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 2 && bad) m3_err = 1'b1;
         else if (clr)      m3_err = 1'b0;
         if (k == 3) m3_valid = m3_valid | oh;
         exp = {(k < 5), (k == 2) ? oh : 3'b000, (k == 4), m3_err, d};
         got = {r3_busy, r3_latch_clk, r3_ack, r3_addr_err, r3_latch_data};
         vec++;
         if (got !== exp) begin
            errs++;
            $display("FAIL addr_err_seq k=%0d addr=%0d clr=%0b got=%h exp=%h", k, a, clr, got, exp);
         end
         if (k == 5) begin
            eoe = ~(m3_valid & {N3{out_en}});
            vec++;
            if (r3_oe_n !== eoe) begin
               errs++;
               $display("FAIL oe3_after_write got=%b exp=%b", r3_oe_n, eoe);
            end
            r3_req = 1'b0; err_clr = 1'b0;
         end
         if (k < 5) @(posedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      isa_req = 1'b1; camac_req = 1'b1; r3_req = 1'b1; out_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vec++;
      if ({busy, latch_clk, isa_ack, camac_ack, latch_data, addr_err, latch_oe_n, shadow_data} !==
          {1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 4'b1111, 8'h00}) begin
         errs++;
         $display("FAIL reset_main busy=%b clk=%b acks=%b%b data=%h err=%b oe=%b sh=%h",
                  busy, latch_clk, isa_ack, camac_ack, latch_data, addr_err, latch_oe_n, shadow_data);
      end
      vec++;
      if ({r3_busy, r3_latch_clk, r3_ack, r3_addr_err, r3_oe_n} !== {1'b0, 3'b000, 1'b0, 1'b0, 3'b111}) begin
         errs++;
         $display("FAIL reset_3latch busy=%b clk=%b ack=%b err=%b oe=%b",
                  r3_busy, r3_latch_clk, r3_ack, r3_addr_err, r3_oe_n);
      end
      do_reset();
   endtask

   task automatic test_basic_write();
      do_reset();
      out_en = 1'b1;
      run_pair(1'b1, 1'b0, 2'd1, 8'hA5, 2'd0, 8'h00);
   endtask

   task automatic test_contention();
      do_reset();
      out_en = 1'b1;
      run_pair(1'b1, 1'b1, 2'd0, 8'h11, 2'd2, 8'h22);
      repeat (4)
         run_pair(1'b1, 1'b1, AW'($urandom), DW'($urandom), AW'($urandom), DW'($urandom));
   endtask

   task automatic test_out_en();
      do_reset();
      out_en = 1'b0;
      run_pair(1'b1, 1'b0, 2'd3, DW'($urandom), 2'd0, 8'h00);
      out_en = 1'b1;
      #1;
      vec++;
      if (latch_oe_n !== 4'b1111) begin
         errs++;
         $display("FAIL oe_before_edge got=%b exp=%b", latch_oe_n, 4'b1111);
      end
      @(posedge clk);
      @(negedge clk);
      vec++;
      if (latch_oe_n !== 4'b0111) begin
         errs++;
         $display("FAIL oe_enable got=%b exp=%b", latch_oe_n, 4'b0111);
      end
   endtask

   task automatic test_reset_abort();
      do_reset();
      out_en = 1'b1;
      run_pair(1'b1, 1'b0, 2'd2, DW'($urandom), 2'd0, 8'h00);
      @(posedge clk); #1;
      isa_req = 1'b1; isa_addr = 2'd0; isa_data = 8'h3C;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vec++;
      if (latch_clk !== 4'b0001) begin
         errs++;
         $display("FAIL abort_strobe_seen got=%b exp=%b", latch_clk, 4'b0001);
      end
      rst_n = 1'b0;
      #1;
      vec++;
      if ({latch_clk, latch_oe_n, busy} !== {4'b0000, 4'b1111, 1'b0}) begin
         errs++;
         $display("FAIL abort_immediate clk=%b oe=%b busy=%b", latch_clk, latch_oe_n, busy);
      end
      do_reset();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         vec++;
         if ({isa_ack, camac_ack, busy} !== 3'b000) begin
            errs++;
            $display("FAIL abort_no_ack k=%0d got=%b exp=000", k, {isa_ack, camac_ack, busy});
         end
      end
      run_pair(1'b1, 1'b0, AW'($urandom), DW'($urandom), 2'd0, 8'h00);
   endtask

   task automatic test_addr_err();
      do_reset();
      out_en = 1'b1;
      r3_txn(2'd3, DW'($urandom), 1'b1);
      r3_txn(2'd3, DW'($urandom), 1'b0);
      @(posedge clk); #1;
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      @(negedge clk);
      vec++;
      if (r3_addr_err !== 1'b0) begin
         errs++;
         $display("FAIL err_clr got=%b exp=0", r3_addr_err);
      end
      m3_err = 1'b0;
      r3_txn(2'd2, DW'($urandom), 1'b0);
      r3_txn(AW'($urandom_range(0, 3)), DW'($urandom), 1'b0);
   endtask

   task automatic test_shadow();
      logic [DW-1:0] e;
      do_reset();
      out_en = 1'b1;
      run_pair(1'b1, 1'b0, 2'd0, 8'h5A, 2'd0, 8'h00);
      shadow_addr = 2'd0;
      #1;
`ifdef SM2201_LATCH_SHADOW_EN
      e = 8'h5A;
`else
      e = 8'h00;
`endif
      vec++;
      if (shadow_data !== e) begin
         errs++;
         $display("FAIL shadow_latch0 got=%h exp=%h", shadow_data, e);
      end
   endtask

   task automatic test_random();
      int u;
      do_reset();
      for (int n = 0; n < 20; n++) begin
         out_en = 1'($urandom);
         u = $urandom_range(1, 3);
         run_pair(u[0], u[1], AW'($urandom), DW'($urandom), AW'($urandom), DW'($urandom));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      isa_req = 1'b0; camac_req = 1'b0; out_en = 1'b0; err_clr = 1'b0;
      isa_addr = '0; camac_addr = '0; shadow_addr = '0;
      isa_data = '0; camac_data = '0;
      r3_req = 1'b0; c3_req = 1'b0; r3_addr = '0; c3_addr = '0; r3_data = '0; c3_data = '0;
      test_reset();
      test_basic_write();
      test_contention();
      test_out_en();
      test_reset_abort();
      test_addr_err();
      test_shadow();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired after %0d vectors", vec);
      $fatal(1);
   end

endmodule
